// File: rtl/secuenciador_alu_condicional_pkg.sv
// rtl/secuenciador_alu_condicional_pkg.sv - shared types and constants for the conditional ALU sequencer
package pkg_secuenciador_alu;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    EVALUA    = 2'd1,
    EJECUTA   = 2'd2,
    RESPUESTA = 2'd3
  } estado_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int BAND_N = 0;
  localparam int BAND_Z = 1;
  localparam int BAND_C = 2;
  localparam int BAND_V = 3;

endpackage

// File: rtl/secuenciador_alu_condicional_evaluador.sv
// rtl/secuenciador_alu_condicional_evaluador.sv - condition code test against the NZCV flags
module evaluador_condicion
  import pkg_secuenciador_alu::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] banderas,
  output logic       pasa
);

  logic n, z, c, v;

  assign n = banderas[BAND_N];
  assign z = banderas[BAND_Z];
  assign c = banderas[BAND_C];
  assign v = banderas[BAND_V];

  always_comb begin
    pasa = 1'b0;
    case (cond)
      COND_EQ: pasa = z;
      COND_NE: pasa = !z;
      COND_CS: pasa = c;
      COND_CC: pasa = !c;
      COND_MI: pasa = n;
      COND_PL: pasa = !n;
      COND_VS: pasa = v;
      COND_VC: pasa = !v;
      COND_HI: pasa = c && !z;
      COND_LS: pasa = !c || z;
      COND_GE: pasa = (n == v);
      COND_LT: pasa = (n != v);
      COND_GT: pasa = !z && (n == v);
      COND_LE: pasa = z || (n != v);
      COND_AL: pasa = 1'b1;
      COND_NV: pasa = 1'b0;
      default: pasa = 1'b0;
    endcase
  end

endmodule

// File: rtl/secuenciador_alu_condicional.sv
// rtl/secuenciador_alu_condicional.sv - conditional op sequencer driving the shared ALU, owns NZCV flags
module secuenciador_alu_condicional
  import pkg_secuenciador_alu::*;
#(
  parameter int ANCHO        = 3,
  parameter int LATENCIA_ALU = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sol_valida,
  output logic             sol_lista,
  input  logic [3:0]       sol_op,
  input  logic [ANCHO:0]   sol_a,
  input  logic [ANCHO:0]   sol_b,
  input  logic [3:0]       sol_cond,
  input  logic             sol_s,
  output logic [3:0]       alu_op,
  output logic [ANCHO:0]   alu_a,
  output logic [ANCHO:0]   alu_b,
  input  logic [ANCHO:0]   alu_resultado,
  input  logic             alu_carry,
  input  logic             alu_borrow,
  input  logic             alu_overflow,
  output logic             res_valida,
  input  logic             res_lista,
  output logic [ANCHO:0]   res_dato,
  output logic             res_ejecutada,
  output logic [3:0]       banderas,
  input  logic             band_escribe,
  input  logic [3:0]       band_dato
);

  localparam int CNT_W = (LATENCIA_ALU > 1) ? $clog2(LATENCIA_ALU) : 1;
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(LATENCIA_ALU - 1);

  estado_t          estado_q, estado_d;
  logic [3:0]       op_q, op_d;
  logic [ANCHO:0]   a_q, a_d;
  logic [ANCHO:0]   b_q, b_d;
  logic [3:0]       cond_q, cond_d;
  logic             s_q, s_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [ANCHO:0]   alu_a_q, alu_a_d;
  logic [ANCHO:0]   alu_b_q, alu_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ANCHO:0]   res_dato_q, res_dato_d;
  logic             res_ejec_q, res_ejec_d;
  logic [3:0]       banderas_q, banderas_d;
  logic             pasa;

  // Evaluated against the registered flags, so a same-cycle external write is not seen
  evaluador_condicion u_evaluador (
    .cond     (cond_q),
    .banderas (banderas_q),
    .pasa     (pasa)
  );

  always_comb begin
    estado_d   = estado_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cond_d     = cond_q;
    s_d        = s_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    cnt_d      = cnt_q;
    res_dato_d = res_dato_q;
    res_ejec_d = res_ejec_q;
    banderas_d = banderas_q;

    case (estado_q)
      INACTIVO: begin
        if (sol_valida) begin
          op_d     = sol_op;
          a_d      = sol_a;
          b_d      = sol_b;
          cond_d   = sol_cond;
          s_d      = sol_s;
          estado_d = EVALUA;
        end
      end
      EVALUA: begin
        if (pasa) begin
          alu_op_d = op_q;
          alu_a_d  = a_q;
          alu_b_d  = b_q;
          cnt_d    = '0;
          estado_d = EJECUTA;
        end else begin
          res_dato_d = '0;
          res_ejec_d = 1'b0;
          estado_d   = RESPUESTA;
        end
      end
      EJECUTA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_FIN) begin
          res_dato_d = alu_resultado;
          res_ejec_d = 1'b1;
          if (s_q) begin
            banderas_d = {alu_overflow, alu_carry, (alu_resultado == '0), alu_borrow};
          end
          estado_d = RESPUESTA;
        end
      end
      RESPUESTA: begin
        if (res_lista) begin
          estado_d = INACTIVO;
        end
      end
      default: estado_d = INACTIVO;
    endcase

    // Context restore overrides any flag update landing on the same edge
    if (band_escribe) begin
      banderas_d = band_dato;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= INACTIVO;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cond_q     <= '0;
      s_q        <= 1'b0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      cnt_q      <= '0;
      res_dato_q <= '0;
      res_ejec_q <= 1'b0;
      banderas_q <= '0;
    end else begin
      estado_q   <= estado_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cond_q     <= cond_d;
      s_q        <= s_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      cnt_q      <= cnt_d;
      res_dato_q <= res_dato_d;
      res_ejec_q <= res_ejec_d;
      banderas_q <= banderas_d;
    end
  end

  assign sol_lista     = (estado_q == INACTIVO);
  assign res_valida    = (estado_q == RESPUESTA);
  assign alu_op        = alu_op_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign res_dato      = res_dato_q;
  assign res_ejecutada = res_ejec_q;
  assign banderas      = banderas_q;

endmodule

// File: tb/tb_secuenciador_alu_condicional.sv
// tb/tb_secuenciador_alu_condicional.sv - self-checking bench for the conditional ALU sequencer
module tb_secuenciador_alu_condicional;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT with LATENCIA_ALU=1
  logic       rst = 1'b1;
  logic       sol_valida = 1'b0, sol_lista, sol_s = 1'b0;
  logic [3:0] sol_op = '0, sol_a = '0, sol_b = '0, sol_cond = '0;
  logic [3:0] alu_op, alu_a, alu_b, alu_resultado;
  logic       alu_carry, alu_borrow, alu_overflow;
  logic       res_valida, res_lista = 1'b0, res_ejecutada;
  logic [3:0] res_dato, banderas;
  logic       band_escribe = 1'b0;
  logic [3:0] band_dato = '0;

  // DUT with LATENCIA_ALU=3
  logic       t3_rst = 1'b1;
  logic       t3_sol_valida = 1'b0, t3_sol_lista, t3_sol_s = 1'b0;
  logic [3:0] t3_sol_op = '0, t3_sol_a = '0, t3_sol_b = '0, t3_sol_cond = '0;
  logic [3:0] t3_alu_op, t3_alu_a, t3_alu_b, t3_alu_resultado;
  logic       t3_alu_carry, t3_alu_borrow, t3_alu_overflow;
  logic       t3_res_valida, t3_res_lista = 1'b0, t3_res_ejecutada;
  logic [3:0] t3_res_dato, t3_banderas;
  logic       t3_band_escribe = 1'b0;
  logic [3:0] t3_band_dato = '0;

  // Bench ALU: op 1 = subtract, anything else = add; borrow output is the result sign
  function automatic logic [6:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic       c, o;
    if (op == 4'd1) begin
      s = {1'b0, a} - {1'b0, b};
      c = ~s[4];
      o = (a[3] != b[3]) && (s[3] != a[3]);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      c = s[4];
      o = (a[3] == b[3]) && (s[3] != a[3]);
    end
    return {o, s[3], c, s[3:0]};
  endfunction

  assign {alu_overflow, alu_borrow, alu_carry, alu_resultado} = alu_f(alu_op, alu_a, alu_b);
  assign {t3_alu_overflow, t3_alu_borrow, t3_alu_carry, t3_alu_resultado} = alu_f(t3_alu_op, t3_alu_a, t3_alu_b);

  secuenciador_alu_condicional #(.ANCHO(3), .LATENCIA_ALU(1)) u_dut (
    .clk(clk), .rst(rst),
    .sol_valida(sol_valida), .sol_lista(sol_lista), .sol_op(sol_op), .sol_a(sol_a), .sol_b(sol_b),
    .sol_cond(sol_cond), .sol_s(sol_s),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_resultado(alu_resultado),
    .alu_carry(alu_carry), .alu_borrow(alu_borrow), .alu_overflow(alu_overflow),
    .res_valida(res_valida), .res_lista(res_lista), .res_dato(res_dato), .res_ejecutada(res_ejecutada),
    .banderas(banderas), .band_escribe(band_escribe), .band_dato(band_dato)
  );

  secuenciador_alu_condicional #(.ANCHO(3), .LATENCIA_ALU(3)) u_dut3 (
    .clk(clk), .rst(t3_rst),
    .sol_valida(t3_sol_valida), .sol_lista(t3_sol_lista), .sol_op(t3_sol_op), .sol_a(t3_sol_a),
    .sol_b(t3_sol_b), .sol_cond(t3_sol_cond), .sol_s(t3_sol_s),
    .alu_op(t3_alu_op), .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_resultado(t3_alu_resultado),
    .alu_carry(t3_alu_carry), .alu_borrow(t3_alu_borrow), .alu_overflow(t3_alu_overflow),
    .res_valida(t3_res_valida), .res_lista(t3_res_lista), .res_dato(t3_res_dato),
    .res_ejecutada(t3_res_ejecutada), .banderas(t3_banderas), .band_escribe(t3_band_escribe),
    .band_dato(t3_band_dato)
  );

  typedef struct {
    logic [3:0] dato;
    logic       ejec;
    logic [3:0] flags;
    int         lat;
    logic [3:0] aop;
    logic [3:0] aa;
    logic [3:0] ab;
  } exp_t;

  typedef struct {
    logic [3:0] pre;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] cond;
    logic       s;
    logic [3:0] dato;
    logic       ejec;
    logic [3:0] flags;
  } vec_t;

  exp_t       cola[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] la_op = '0, la_a = '0, la_b = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Independent condition model: even codes test a base predicate, odd codes its inverse
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[0]; z = f[1]; cy = f[2]; v = f[3];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic write_flags(input logic [3:0] v);
    band_escribe = 1'b1;
    band_dato    = v;
    @(negedge clk);
    band_escribe = 1'b0;
  endtask

  // Entered just after a negedge; returns at the negedge following the accept edge
  task automatic handshake(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] cond, input logic s,
                           input logic [3:0] dato, input logic ejec, input logic [3:0] flags);
    exp_t e;
    int   w;
    sol_op = op; sol_a = a; sol_b = b; sol_cond = cond; sol_s = s;
    sol_valida = 1'b1;
    w = 0;
    while (!sol_lista && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", 32'(sol_lista), 32'd1);
    if (ejec) begin
      la_op = op; la_a = a; la_b = b;
    end
    e.dato = dato; e.ejec = ejec; e.flags = flags; e.lat = ejec ? 3 : 2;
    e.aop = la_op; e.aa = la_a; e.ab = la_b;
    cola.push_back(e);
    @(posedge clk);
    @(negedge clk);
    sol_valida = 1'b0;
  endtask

  task automatic collect(input int n0, input int stall);
    exp_t e;
    int   n;
    n = n0;
    while (!res_valida && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (cola.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = cola.pop_front();
      chk("latency", 32'(n), 32'(e.lat));
      chk("res_dato", 32'(res_dato), 32'(e.dato));
      chk("res_ejecutada", 32'(res_ejecutada), 32'(e.ejec));
      chk("banderas", 32'(banderas), 32'(e.flags));
      chk("alu_op", 32'(alu_op), 32'(e.aop));
      chk("alu_a", 32'(alu_a), 32'(e.aa));
      chk("alu_b", 32'(alu_b), 32'(e.ab));
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_res_valida", 32'(res_valida), 32'd1);
        chk("stall_res_dato", 32'(res_dato), 32'(e.dato));
        chk("stall_res_ejecutada", 32'(res_ejecutada), 32'(e.ejec));
        chk("stall_sol_lista", 32'(sol_lista), 32'd0);
      end
    end
    res_lista = 1'b1;
    @(negedge clk);
    res_lista = 1'b0;
  endtask

  vec_t tabla[10];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tabla[0] = '{4'h0, 4'd0, 4'd7, 4'd9, 4'hE, 1'b1, 4'h0, 1'b1, 4'b0110};
    tabla[1] = '{4'h0, 4'd0, 4'd1, 4'd1, 4'h0, 1'b1, 4'h0, 1'b0, 4'b0000};
    tabla[2] = '{4'h0, 4'd0, 4'd3, 4'd4, 4'hE, 1'b1, 4'h7, 1'b1, 4'b0000};
    tabla[3] = '{4'h0, 4'd0, 4'd5, 4'd5, 4'hE, 1'b1, 4'hA, 1'b1, 4'b1001};
    tabla[4] = '{4'h0, 4'd1, 4'd2, 4'd5, 4'hE, 1'b0, 4'hD, 1'b1, 4'b0000};
    tabla[5] = '{4'h9, 4'd1, 4'd5, 4'd5, 4'hA, 1'b1, 4'h0, 1'b1, 4'b0110};
    tabla[6] = '{4'h2, 4'd0, 4'd3, 4'd3, 4'hC, 1'b1, 4'h0, 1'b0, 4'b0010};
    tabla[7] = '{4'h4, 4'd0, 4'hF, 4'd1, 4'h8, 1'b1, 4'h0, 1'b1, 4'b0110};
    tabla[8] = '{4'h0, 4'd0, 4'd2, 4'd2, 4'hF, 1'b1, 4'h0, 1'b0, 4'b0000};
    tabla[9] = '{4'h1, 4'd1, 4'd0, 4'd1, 4'hB, 1'b1, 4'hF, 1'b1, 4'b0001};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    t3_rst = 1'b0;
    @(negedge clk);

    chk("reset_sol_lista", 32'(sol_lista), 32'd1);
    chk("reset_res_valida", 32'(res_valida), 32'd0);
    chk("reset_banderas", 32'(banderas), 32'd0);
    chk("reset_res_dato", 32'(res_dato), 32'd0);
    chk("reset_res_ejecutada", 32'(res_ejecutada), 32'd0);
    chk("reset_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);

    for (int i = 0; i < 10; i++) begin
      write_flags(tabla[i].pre);
      handshake(tabla[i].op, tabla[i].a, tabla[i].b, tabla[i].cond, tabla[i].s,
                tabla[i].dato, tabla[i].ejec, tabla[i].flags);
      collect(1, 0);
    end

    // Backpressure with a request held on sol_valida during the stall
    write_flags(4'h0);
    handshake(4'd0, 4'd2, 4'd3, 4'hE, 1'b0, 4'h5, 1'b1, 4'h0);
    sol_op = 4'd0; sol_a = 4'd1; sol_b = 4'd1; sol_cond = 4'hE; sol_s = 1'b0;
    sol_valida = 1'b1;
    collect(1, 4);
    handshake(4'd0, 4'd1, 4'd1, 4'hE, 1'b0, 4'h2, 1'b1, 4'h0);
    collect(1, 0);

    // External flag write on the same edge as an s=1 update
    write_flags(4'h0);
    handshake(4'd0, 4'd7, 4'd9, 4'hE, 1'b1, 4'h0, 1'b1, 4'b1001);
    @(negedge clk);
    band_escribe = 1'b1;
    band_dato    = 4'b1001;
    @(negedge clk);
    band_escribe = 1'b0;
    collect(3, 0);

    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        logic ok;
        ok = cond_ok(4'(c), 4'(f));
        write_flags(4'(f));
        handshake(4'd0, 4'd1, 4'd2, 4'(c), 1'b0, ok ? 4'h3 : 4'h0, ok, 4'(f));
        collect(1, 0);
      end
    end

    // LATENCIA_ALU=3 instance: one full transaction, then reset mid-execution
    begin
      int n;
      t3_sol_op = 4'd0; t3_sol_a = 4'd2; t3_sol_b = 4'd3; t3_sol_cond = 4'hE; t3_sol_s = 1'b0;
      t3_sol_valida = 1'b1;
      @(negedge clk);
      t3_sol_valida = 1'b0;
      n = 1;
      while (!t3_res_valida && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("lat3_latency", 32'(n), 32'd5);
      chk("lat3_res_dato", 32'(t3_res_dato), 32'd5);
      t3_res_lista = 1'b1;
      @(negedge clk);
      t3_res_lista = 1'b0;

      t3_band_escribe = 1'b1;
      t3_band_dato    = 4'hF;
      @(negedge clk);
      t3_band_escribe = 1'b0;
      chk("lat3_flags_preset", 32'(t3_banderas), 32'hF);
      t3_sol_s = 1'b1;
      t3_sol_valida = 1'b1;
      @(negedge clk);
      t3_sol_valida = 1'b0;
      @(negedge clk);
      @(negedge clk);
      t3_rst = 1'b1;
      @(negedge clk);
      t3_rst = 1'b0;
      chk("lat3_rst_sol_lista", 32'(t3_sol_lista), 32'd1);
      chk("lat3_rst_res_valida", 32'(t3_res_valida), 32'd0);
      chk("lat3_rst_banderas", 32'(t3_banderas), 32'd0);
      chk("lat3_rst_res", 32'({t3_res_dato, t3_res_ejecutada}), 32'd0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (t3_res_valida) n++;
      end
      chk("lat3_no_response", 32'(n), 32'd0);
    end

    chk("scoreboard_drained", 32'(cola.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
